// File: rtl/ex_8_5_arb_pkg.sv
// Shared types and defaults for the ex_8_5 multiplier arbiter.
// Optional watchdog in ex_8_5_arb is enabled with ARB_TIMEOUT_EN.
package ex_8_5_arb_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN,
        S_RESP
    } arb_state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_DP_WIDTH = 5;
    localparam int DEF_TIMEOUT  = 64;

    function automatic int ptr_width(input int n_req);
        return (n_req > 1) ? $clog2(n_req) : 1;
    endfunction

endpackage

// File: rtl/ex_8_5_arb_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching upward with wrap. Returns one-hot winner and its index.
module rr_pick
    import ex_8_5_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int PTR_W = ptr_width(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win_oh,
    output logic [PTR_W-1:0] win_idx,
    output logic             win_any
);

    int               slot;
    logic [PTR_W-1:0] slot_idx;

    always_comb begin
        win_oh   = '0;
        win_idx  = '0;
        win_any  = 1'b0;
        slot     = 0;
        slot_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            slot = int'(ptr) + i;
            if (slot >= N_REQ) slot = slot - N_REQ;
            slot_idx = slot[PTR_W-1:0];
            if (!win_any && req[slot_idx]) begin
                win_any          = 1'b1;
                win_oh[slot_idx] = 1'b1;
                win_idx          = slot_idx;
            end
        end
    end

endmodule

// File: rtl/ex_8_5_arb.sv
// Round-robin arbiter sharing one ex_8_5 shift-add multiplier among N_REQ requesters.
// Define ARB_TIMEOUT_EN to add a watchdog that ends a stalled service with err=1.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for mul_rdy and a request; picks winner, latches operands
//   S_ISSUE | mul_start high until the multiplier drops mul_rdy
//   S_RUN   | waiting for mul_rdy to return; captures mul_product
//   S_RESP  | done pulse to winner, gnt cleared, pointer advanced
module ex_8_5_arb
    import ex_8_5_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int DP_WIDTH = DEF_DP_WIDTH,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DP_WIDTH-1:0] req_multiplicand,
    input  logic [N_REQ*DP_WIDTH-1:0] req_multiplier,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          done,
    output logic [2*DP_WIDTH-1:0]     product,
    output logic                      err,
    output logic                      mul_start,
    output logic [DP_WIDTH-1:0]       mul_multiplicand,
    output logic [DP_WIDTH-1:0]       mul_multiplier,
    input  logic [2*DP_WIDTH-1:0]     mul_product,
    input  logic                      mul_rdy
);

    localparam int PTR_W = ptr_width(N_REQ);

    arb_state_t            state, state_nxt;
    logic [PTR_W-1:0]      ptr, ptr_nxt;
    logic [PTR_W-1:0]      win_idx_q, win_idx_nxt;
    logic [N_REQ-1:0]      gnt_nxt, done_nxt;
    logic [2*DP_WIDTH-1:0] product_nxt;
    logic                  mul_start_nxt;
    logic [DP_WIDTH-1:0]   mcand_nxt, mplier_nxt;
    logic                  err_nxt;

    logic [N_REQ-1:0]      pick_oh;
    logic [PTR_W-1:0]      pick_idx;
    logic                  pick_any;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .win_oh  (pick_oh),
        .win_idx (pick_idx),
        .win_any (pick_any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    logic            err_q;

    assign wd_expired = ((state == S_ISSUE) || (state == S_RUN)) && (wd_cnt == '0);
    assign err        = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        win_idx_nxt   = win_idx_q;
        gnt_nxt       = gnt;
        done_nxt      = '0;
        product_nxt   = product;
        mul_start_nxt = mul_start;
        mcand_nxt     = mul_multiplicand;
        mplier_nxt    = mul_multiplier;
        err_nxt       = 1'b0;
`ifdef ARB_TIMEOUT_EN
        err_nxt       = err_q;
`endif
        case (state)
            S_IDLE: begin
                if (mul_rdy && pick_any) begin
                    state_nxt     = S_ISSUE;
                    gnt_nxt       = pick_oh;
                    win_idx_nxt   = pick_idx;
                    mul_start_nxt = 1'b1;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (pick_oh[i]) begin
                            mcand_nxt  = req_multiplicand[i*DP_WIDTH +: DP_WIDTH];
                            mplier_nxt = req_multiplier[i*DP_WIDTH +: DP_WIDTH];
                        end
                    end
                end
            end
            S_ISSUE: begin
                if (!mul_rdy) begin
                    state_nxt     = S_RUN;
                    mul_start_nxt = 1'b0;
                end
            end
            S_RUN: begin
                if (mul_rdy) begin
                    state_nxt   = S_RESP;
                    product_nxt = mul_product;
                    done_nxt    = gnt;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
                gnt_nxt   = '0;
                err_nxt   = 1'b0;
                ptr_nxt   = (win_idx_q == PTR_W'(N_REQ - 1)) ? '0 : win_idx_q + 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
`ifdef ARB_TIMEOUT_EN
        // A genuine completion on the expiry edge keeps its real result.
        if (wd_expired && (state_nxt != S_RESP)) begin
            state_nxt     = S_RESP;
            done_nxt      = gnt;
            product_nxt   = '0;
            mul_start_nxt = 1'b0;
            err_nxt       = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state            <= S_IDLE;
            ptr              <= '0;
            win_idx_q        <= '0;
            gnt              <= '0;
            done             <= '0;
            product          <= '0;
            mul_start        <= 1'b0;
            mul_multiplicand <= '0;
            mul_multiplier   <= '0;
        end else begin
            state            <= state_nxt;
            ptr              <= ptr_nxt;
            win_idx_q        <= win_idx_nxt;
            gnt              <= gnt_nxt;
            done             <= done_nxt;
            product          <= product_nxt;
            mul_start        <= mul_start_nxt;
            mul_multiplicand <= mcand_nxt;
            mul_multiplier   <= mplier_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Down-counter loaded on entry to ISSUE; expiry at zero gives TIMEOUT cycles.
    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q <= err_nxt;
            if ((state == S_IDLE) && (state_nxt == S_ISSUE)) begin
                wd_cnt <= WD_W'(TIMEOUT - 1);
            end else if (((state == S_ISSUE) || (state == S_RUN)) && (wd_cnt != '0)) begin
                wd_cnt <= wd_cnt - 1'b1;
            end
        end
    end
`else
    logic unused_err_nxt;
    assign unused_err_nxt = err_nxt;
`endif

endmodule

// File: tb/tb_ex_8_5_arb.sv
// Directed bench for ex_8_5_arb with a behavioural multiplier model.
// Timeout steps are included when ARB_TIMEOUT_EN is defined.
module tb_ex_8_5_arb;

    localparam int N       = 4;
    localparam int W       = 5;
    localparam int MUL_LAT = 3;

    logic           clk = 1'b0;
    logic           rstb;
    logic [N-1:0]   req;
    logic [N*W-1:0] mcand_v, mplier_v;
    logic [N-1:0]   gnt, done;
    logic [2*W-1:0] product;
    logic           err, mul_start;
    logic [W-1:0]   mul_multiplicand, mul_multiplier;
    logic [2*W-1:0] mul_product;
    logic           mul_rdy;

    int n_cmp  = 0;
    int n_fail = 0;

    logic           m_busy, m_hold0, m_stuck;
    int             m_cnt;
    logic [2*W-1:0] m_calc;

    always #5 clk = ~clk;

    ex_8_5_arb #(.N_REQ(N), .DP_WIDTH(W), .TIMEOUT(64)) dut (
        .clk              (clk),
        .rstb             (rstb),
        .req              (req),
        .req_multiplicand (mcand_v),
        .req_multiplier   (mplier_v),
        .gnt              (gnt),
        .done             (done),
        .product          (product),
        .err              (err),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .mul_rdy          (mul_rdy)
    );

    // Multiplier model: accepts start while ready, busy MUL_LAT+1 cycles.
    assign mul_rdy = !m_busy && !m_hold0;

    always @(posedge clk or posedge rstb) begin
        if (rstb) begin
            m_busy      <= 1'b0;
            m_cnt       <= 0;
            m_calc      <= '0;
            mul_product <= '0;
        end else if (!m_busy) begin
            if (mul_start && mul_rdy) begin
                m_busy <= 1'b1;
                m_cnt  <= MUL_LAT;
                m_calc <= (2*W)'(mul_multiplicand) * (2*W)'(mul_multiplier);
            end
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end else if (!m_stuck) begin
            m_busy      <= 1'b0;
            mul_product <= m_calc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        mcand_v[idx*W +: W]  = a;
        mplier_v[idx*W +: W] = b;
    endtask

    task automatic wait_gnt(input string tag);
        int t;
        t = 0;
        while (gnt == '0 && t < 100) begin
            step();
            t++;
        end
        check({tag, ":gnt_seen"}, 32'(gnt != '0), 32'd1);
    endtask

    // One full service: grant, operands, stable gnt, done/product/err, release.
    task automatic serve(input string tag, input logic [N-1:0] exp_gnt,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2*W-1:0] exp_prod, input logic exp_err,
                         input logic [N-1:0] req_after, input logic scramble,
                         output int cycles);
        logic stable;
        int   t;
        wait_gnt(tag);
        check({tag, ":gnt"}, 32'(gnt), 32'(exp_gnt));
        check({tag, ":start"}, 32'(mul_start), 32'd1);
        check({tag, ":mcand"}, 32'(mul_multiplicand), 32'(a));
        check({tag, ":mplier"}, 32'(mul_multiplier), 32'(b));
        if (scramble) begin
            mcand_v  = ~mcand_v;
            mplier_v = ~mplier_v;
        end
        stable = 1'b1;
        t = 0;
        while (done == '0 && t < 200) begin
            if (gnt !== exp_gnt) stable = 1'b0;
            step();
            t++;
        end
        cycles = t;
        check({tag, ":gnt_held"}, 32'(stable), 32'd1);
        check({tag, ":done"}, 32'(done), 32'(exp_gnt));
        check({tag, ":product"}, 32'(product), 32'(exp_prod));
        check({tag, ":err"}, 32'(err), 32'(exp_err));
        req = req_after;
        step();
        check({tag, ":done_pulse"}, 32'(done), 32'd0);
        check({tag, ":gnt_clr"}, 32'(gnt), 32'd0);
    endtask

    initial begin
        int            cyc;
        logic [N-1:0]  order [5];
        logic [2*W-1:0] prods [5];
        logic [W-1:0]  opa [5];
        logic [W-1:0]  opb [5];
        logic          quiet;

        rstb     = 1'b1;
        req      = '0;
        mcand_v  = '0;
        mplier_v = '0;
        m_hold0  = 1'b0;
        m_stuck  = 1'b0;
        step();
        check("rst:gnt", 32'(gnt), 32'd0);
        check("rst:done", 32'(done), 32'd0);
        check("rst:product", 32'(product), 32'd0);
        check("rst:err", 32'(err), 32'd0);
        check("rst:start", 32'(mul_start), 32'd0);
        check("rst:ops", 32'({mul_multiplicand, mul_multiplier}), 32'd0);
        rstb = 1'b0;

        // Single service from requester 3; operands changed after grant are ignored.
        set_ops(3, 5'd23, 5'd19);
        req = 4'b1000;
        serve("single", 4'b1000, 5'd23, 5'd19, 10'd437, 1'b0, 4'b0000, 1'b1, cyc);
        step();
        step();
        check("single:product_hold", 32'(product), 32'd437);

        // All four requesting from reset: 0,1,2,3,0 with exact 2-cycle gap.
        rstb = 1'b1;
        step();
        set_ops(0, 5'd31, 5'd31);
        set_ops(1, 5'd3, 5'd7);
        set_ops(2, 5'd17, 5'd2);
        set_ops(3, 5'd12, 5'd30);
        req = 4'b1111;
        step();
        rstb = 1'b0;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prods = '{10'd961, 10'd21, 10'd34, 10'd360, 10'd961};
        opa   = '{5'd31, 5'd3, 5'd17, 5'd12, 5'd31};
        opb   = '{5'd31, 5'd7, 5'd2, 5'd30, 5'd31};
        for (int i = 0; i < 5; i++) begin
            serve("all", order[i], opa[i], opb[i], prods[i], 1'b0,
                  (i == 4) ? 4'b0000 : 4'b1111, 1'b0, cyc);
            if (i < 4) begin
                step();
                check("all:next_gnt", 32'(gnt), 32'(order[i+1]));
            end
        end

        // Serve 1, then 0 and 2 together: pointer favours 2.
        req = 4'b0010;
        serve("rr_one", 4'b0010, 5'd3, 5'd7, 10'd21, 1'b0, 4'b0000, 1'b0, cyc);
        req = 4'b0101;
        serve("rr_two", 4'b0100, 5'd17, 5'd2, 10'd34, 1'b0, 4'b0001, 1'b0, cyc);
        serve("rr_zero", 4'b0001, 5'd31, 5'd31, 10'd961, 1'b0, 4'b0000, 1'b0, cyc);

        // Multiplier not ready: nothing granted until mul_rdy rises.
        m_hold0 = 1'b1;
        req     = 4'b0010;
        quiet   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (gnt != '0 || mul_start) quiet = 1'b0;
        end
        check("blocked:quiet", 32'(quiet), 32'd1);
        m_hold0 = 1'b0;
        step();
        check("blocked:gnt_1cyc", 32'(gnt), 32'b0010);
        serve("blocked", 4'b0010, 5'd3, 5'd7, 10'd21, 1'b0, 4'b0000, 1'b0, cyc);

        // Reset during RUN: outputs clear at once, no done, restart from ptr=0.
        req = 4'b0110;
        wait_gnt("rstrun");
        check("rstrun:gnt", 32'(gnt), 32'b0100);
        cyc = 0;
        while (mul_start && cyc < 20) begin
            step();
            cyc++;
        end
        check("rstrun:in_run", 32'({mul_start, done == '0, gnt}), 32'({1'b0, 1'b1, 4'b0100}));
        rstb = 1'b1;
        #1;
        check("rstrun:async_clr", 32'({gnt, done, mul_start, err}), 32'd0);
        check("rstrun:product_clr", 32'(product), 32'd0);
        check("rstrun:ops_clr", 32'({mul_multiplicand, mul_multiplier}), 32'd0);
        quiet = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            if (done != '0) quiet = 1'b0;
        end
        check("rstrun:no_done", 32'(quiet), 32'd1);
        rstb = 1'b0;
        serve("rstrun_after", 4'b0010, 5'd3, 5'd7, 10'd21, 1'b0, 4'b0000, 1'b0, cyc);

`ifdef ARB_TIMEOUT_EN
        // Multiplier stalls after accept: watchdog ends the service after 64 cycles.
        m_stuck = 1'b1;
        req     = 4'b0001;
        serve("tmo", 4'b0001, 5'd31, 5'd31, 10'd0, 1'b1, 4'b0010, 1'b0, cyc);
        check("tmo:cycles", 32'(cyc), 32'd64);
        m_stuck = 1'b0;
        serve("tmo_next", 4'b0010, 5'd3, 5'd7, 10'd21, 1'b0, 4'b0000, 1'b0, cyc);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
